// File: rtl/placar_pkg.sv
// Shared types and constants for the round controller and score arbiter.
package placar_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int unsigned SCORE_W       = 10;
    localparam int unsigned SCORE_MAX_DEF = 999;

    // Index width for an N-entry vector; a single entry still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controle_placar_if.sv
// Game inputs and score/status outputs between the game logic and controle_placar.
interface controle_placar_if #(
    parameter int unsigned N_INIMIGOS = 32
);
    import placar_pkg::*;

    logic [N_INIMIGOS-1:0] inimigosvida;
    logic                  iniciarJogo;
    logic                  perdeuJogo;
    logic                  reiniciarJogo;
    logic [1:0]            estado;
    logic [SCORE_W-1:0]    placarAtual;
    logic [SCORE_W-1:0]    placarMaximo;
    logic                  pontoPulso;
    logic                  novoRecorde;
    logic                  volta;

    modport master (
        output inimigosvida, iniciarJogo, perdeuJogo, reiniciarJogo,
        input  estado, placarAtual, placarMaximo, pontoPulso, novoRecorde, volta
    );

    modport slave (
        input  inimigosvida, iniciarJogo, perdeuJogo, reiniciarJogo,
        output estado, placarAtual, placarMaximo, pontoPulso, novoRecorde, volta
    );

endinterface

// File: rtl/controle_placar_arbitro_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module arbitro_rr
    import placar_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    int unsigned k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) k = k - N;
            if (!valid && req[IW'(k)]) begin
                valid          = 1'b1;
                grant[IW'(k)]  = 1'b1;
                grant_idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/controle_placar.sv
// Round sequencer, kill-edge detector and round-robin score incrementer.
module controle_placar
    import placar_pkg::*;
#(
    parameter int unsigned N_INIMIGOS = 32,
    parameter int unsigned SCORE_MAX  = SCORE_MAX_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    controle_placar_if.slave   bus
);

    localparam int unsigned IW = idx_w(N_INIMIGOS);

    estado_t                 state_q, state_d;
    logic [N_INIMIGOS-1:0]   vida_q;
    logic [N_INIMIGOS-1:0]   pending_q, pending_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [SCORE_W-1:0]      placar_q, placar_d;
    logic [SCORE_W-1:0]      max_q, max_d;
    logic                    pulso_q, pulso_d;
    logic                    nrec_q, nrec_d;
    logic                    volta_q, volta_d;

    logic [N_INIMIGOS-1:0]   kill;
    logic [N_INIMIGOS-1:0]   gnt;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_valid;
    logic                    gnt_fire;
    logic                    round_start;
    logic                    at_max;
    logic [SCORE_W-1:0]      placar_inc;

    arbitro_rr #(.N(N_INIMIGOS), .IW(IW)) u_arb (
        .req       (pending_q),
        .ptr       (ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .valid     (gnt_valid)
    );

    assign kill       = vida_q & ~bus.inimigosvida;
    assign at_max     = (placar_q == SCORE_W'(SCORE_MAX));
    assign placar_inc = at_max ? '0 : placar_q + SCORE_W'(1);

    // Round FSM plus arbitration/score next-state.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        placar_d    = placar_q;
        max_d       = max_q;
        pulso_d     = 1'b0;
        nrec_d      = nrec_q;
        volta_d     = volta_q;
        round_start = 1'b0;
        gnt_fire    = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (bus.iniciarJogo) begin
                    state_d     = JOGANDO;
                    round_start = 1'b1;
                end
            end
            JOGANDO: begin
                if (bus.perdeuJogo) begin
                    state_d   = FIM;
                    pending_d = '0;
                end else if (bus.reiniciarJogo) begin
                    round_start = 1'b1;
                end else begin
                    gnt_fire  = gnt_valid;
                    // A fresh kill on the granted bit survives the clear.
                    pending_d = (pending_q & ~gnt) | kill;
                end
            end
            FIM: begin
                if (bus.reiniciarJogo || bus.iniciarJogo) begin
                    state_d     = JOGANDO;
                    round_start = 1'b1;
                end
            end
            default: state_d = OCIOSO;
        endcase

        if (gnt_fire) begin
            ptr_d    = (gnt_idx == IW'(N_INIMIGOS - 1)) ? '0 : gnt_idx + IW'(1);
            placar_d = placar_inc;
            pulso_d  = 1'b1;
            if (at_max) volta_d = 1'b1;
            if (placar_inc > max_q) begin
                max_d  = placar_inc;
                nrec_d = 1'b1;
            end
        end

        if (round_start) begin
            placar_d  = '0;
            pending_d = '0;
            ptr_d     = '0;
            nrec_d    = 1'b0;
            volta_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= OCIOSO;
            vida_q    <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            placar_q  <= '0;
            max_q     <= '0;
            pulso_q   <= 1'b0;
            nrec_q    <= 1'b0;
            volta_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vida_q    <= bus.inimigosvida;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            placar_q  <= placar_d;
            max_q     <= max_d;
            pulso_q   <= pulso_d;
            nrec_q    <= nrec_d;
            volta_q   <= volta_d;
        end
    end

    assign bus.estado       = 2'(state_q);
    assign bus.placarAtual  = placar_q;
    assign bus.placarMaximo = max_q;
    assign bus.pontoPulso   = pulso_q;
    assign bus.novoRecorde  = nrec_q;
    assign bus.volta        = volta_q;

endmodule

// File: tb/tb_controle_placar.sv
// Directed bench for controle_placar; a monitor checks every point pulse against a queue.
module tb_controle_placar;

    typedef struct {
        int idx;
        int score;
        int maxs;
        int nrec;
        int volta;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   last_idx = -1;
    int   s;
    exp_t exp_q[$];
    exp_t mon_e;

    controle_placar_if #(.N_INIMIGOS(32)) bus ();

    controle_placar #(.N_INIMIGOS(32), .SCORE_MAX(999)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int score, input int maxs, input int nrec, input int volta);
        exp_t e;
        e.idx = idx; e.score = score; e.maxs = maxs; e.nrec = nrec; e.volta = volta;
        exp_q.push_back(e);
    endtask

    task automatic check_all(input string tag, input int est, input int pa, input int pm,
                             input int pp, input int nr, input int vo);
        check({tag, "_estado"},       int'(bus.estado),       est);
        check({tag, "_placarAtual"},  int'(bus.placarAtual),  pa);
        check({tag, "_placarMaximo"}, int'(bus.placarMaximo), pm);
        check({tag, "_pontoPulso"},   int'(bus.pontoPulso),   pp);
        check({tag, "_novoRecorde"},  int'(bus.novoRecorde),  nr);
        check({tag, "_volta"},        int'(bus.volta),        vo);
    endtask

    // Monitor: every pontoPulso must match the oldest expected point.
    always @(negedge clk) begin
        if (bus.pontoPulso) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(bus.pontoPulso), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_idx",    last_idx,                 mon_e.idx);
                check("pt_placar",    int'(bus.placarAtual),    mon_e.score);
                check("pt_maximo",    int'(bus.placarMaximo),   mon_e.maxs);
                check("pt_recorde",   int'(bus.novoRecorde),    mon_e.nrec);
                check("pt_volta",     int'(bus.volta),          mon_e.volta);
            end
        end
        if (dut.gnt_fire) last_idx = int'(dut.gnt_idx);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.inimigosvida  = '1;
        bus.iniciarJogo   = 1'b0;
        bus.perdeuJogo    = 1'b0;
        bus.reiniciarJogo = 1'b0;
        repeat (2) tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Kill while idle, then start with that flag already low: no points.
        bus.inimigosvida[5] = 1'b0;
        repeat (2) tick();
        check("idle_estado", int'(bus.estado), 0);
        bus.iniciarJogo = 1'b1;
        tick();
        bus.iniciarJogo = 1'b0;
        check("start_estado", int'(bus.estado), 1);
        repeat (4) tick();
        check("idle_kill_ignored", int'(bus.placarAtual), 0);
        bus.inimigosvida[5] = 1'b1;
        tick();

        // Burst of three kills: grants 3, 7, 20 on consecutive cycles.
        bus.inimigosvida[3]  = 1'b0;
        bus.inimigosvida[7]  = 1'b0;
        bus.inimigosvida[20] = 1'b0;
        push(3, 1, 1, 1, 0);
        push(7, 2, 2, 1, 0);
        push(20, 3, 3, 1, 0);
        repeat (2) tick();
        check("burst_latency", exp_q.size(), 3);
        repeat (3) tick();
        check("burst_drained", exp_q.size(), 0);
        check("burst_placar", int'(bus.placarAtual), 3);
        check("burst_maximo", int'(bus.placarMaximo), 3);
        check("burst_recorde", int'(bus.novoRecorde), 1);
        bus.inimigosvida[3]  = 1'b1;
        bus.inimigosvida[7]  = 1'b1;
        bus.inimigosvida[20] = 1'b1;
        tick();

        // Move the pointer to 8, then kills 2 and 9 must grant 9 first.
        bus.inimigosvida[7] = 1'b0;
        push(7, 4, 4, 1, 0);
        repeat (4) tick();
        bus.inimigosvida[7] = 1'b1;
        tick();
        bus.inimigosvida[2] = 1'b0;
        bus.inimigosvida[9] = 1'b0;
        push(9, 5, 5, 1, 0);
        push(2, 6, 6, 1, 0);
        repeat (5) tick();
        bus.inimigosvida[2] = 1'b1;
        bus.inimigosvida[9] = 1'b1;
        tick();
        check("rr_drained", exp_q.size(), 0);

        // Preload to 998: pointer is 3, so each full burst grants 3..31, 0..2.
        s = 6;
        for (int rep = 0; rep < 31; rep++) begin
            bus.inimigosvida = '0;
            for (int j = 0; j < 32; j++) begin
                s++;
                push((3 + j) % 32, s, s, 1, 0);
            end
            tick();
            bus.inimigosvida = '1;
            repeat (33) tick();
        end
        check("preload_placar", int'(bus.placarAtual), 998);

        bus.inimigosvida[3] = 1'b0;
        push(3, 999, 999, 1, 0);
        repeat (4) tick();
        bus.inimigosvida[3] = 1'b1;
        tick();
        check("max_placar", int'(bus.placarAtual), 999);
        bus.inimigosvida[4] = 1'b0;
        push(4, 0, 999, 1, 1);
        repeat (4) tick();
        bus.inimigosvida[4] = 1'b1;
        tick();
        check("wrap_placar", int'(bus.placarAtual), 0);
        check("wrap_volta", int'(bus.volta), 1);
        check("wrap_maximo", int'(bus.placarMaximo), 999);

        // Lose with five kills pending: no grants, score frozen.
        bus.inimigosvida[15] = 1'b0;
        push(15, 1, 999, 1, 1);
        repeat (4) tick();
        bus.inimigosvida[15] = 1'b1;
        tick();
        bus.inimigosvida[14:10] = '0;
        tick();
        bus.perdeuJogo = 1'b1;
        tick();
        bus.perdeuJogo = 1'b0;
        check("lose_estado", int'(bus.estado), 2);
        check("lose_placar", int'(bus.placarAtual), 1);
        bus.inimigosvida[14:10] = '1;
        bus.inimigosvida[0]     = 1'b0;
        repeat (4) tick();
        check("fim_frozen", int'(bus.placarAtual), 1);
        check("fim_estado", int'(bus.estado), 2);
        bus.inimigosvida[0] = 1'b1;
        tick();
        bus.reiniciarJogo = 1'b1;
        tick();
        bus.reiniciarJogo = 1'b0;
        check_all("restart", 1, 0, 999, 0, 0, 0);
        repeat (4) tick();
        check("restart_no_stale", int'(bus.placarAtual), 0);

        // Reset in the middle of a drain.
        bus.inimigosvida[7:0] = '0;
        push(0, 1, 999, 0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.inimigosvida = '1;
        repeat (4) tick();
        check_all("post_reset", 0, 0, 0, 0, 0, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_placar.md
# controle_placar

Game-round controller and kill-event arbiter in front of the score datapath. It watches the per-enemy alive flags and detects every alive→dead transition. Detected kills are queued as pending requests and granted round-robin, one per cycle, as score increments. It also sequences the round (idle / playing / over) and maintains the current and best scores that feed the 7-segment display block and LEDs.

## Interface
- N_INIMIGOS, 32, number of enemy alive flags (1..1000)
- SCORE_MAX, 999, last representable score; the next increment wraps to 0
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- inimigosvida  in  N_INIMIGOS  bit i = 1 while enemy i is alive
- iniciarJogo  in  1  single-cycle pulse, start a round from OCIOSO
- perdeuJogo  in  1  level or pulse, player lost
- reiniciarJogo  in  1  single-cycle pulse, restart the round
- estado  out  2  0 = OCIOSO, 1 = JOGANDO, 2 = FIM
- placarAtual  out  10  current score, binary 0..SCORE_MAX
- placarMaximo  out  10  best score since reset
- pontoPulso  out  1  high for one cycle each time placarAtual increments
- novoRecorde  out  1  sticky per round; set when this round raised placarMaximo
- volta  out  1  sticky per round; set when the score wrapped

## Operation
- Reset values: estado = OCIOSO, placarAtual = 0, placarMaximo = 0, pontoPulso = 0, novoRecorde = 0, volta = 0, pending = 0, RR pointer = 0. vida_q loads inimigosvida on the first clock after reset release.
- vida_q registers inimigosvida every cycle, in all states.
- Kill detection: vida_q[i] & ~inimigosvida[i]. Only in JOGANDO, when no perdeuJogo or reiniciarJogo is present in the same cycle, each detected kill ORs into pending[i].
- Arbiter: round-robin over pending, starting at the RR pointer. Each cycle in JOGANDO with pending ≠ 0:
  - clear the granted bit
  - set the pointer to granted + 1, mod N
  - increment placarAtual and pulse pontoPulso
- If a new kill and the grant hit the same bit in the same cycle, the set wins, so the kill is counted again later.
- Increment arithmetic: if placarAtual == SCORE_MAX, the next value is 0 and volta is set. Otherwise the next value is placarAtual + 1.
- Best-score update, on the same edge as the increment: if the next value > placarMaximo, placarMaximo takes the next value and novoRecorde is set. A wrap never lowers placarMaximo.
- FSM transitions:
  - OCIOSO → JOGANDO on iniciarJogo.
  - JOGANDO → FIM on perdeuJogo, which has priority over reiniciarJogo and over a grant in that cycle.
  - JOGANDO → JOGANDO (restart) on reiniciarJogo.
  - FIM → JOGANDO on reiniciarJogo or iniciarJogo.
  - perdeuJogo is ignored outside JOGANDO.
- Round start (any entry to, or restart of, JOGANDO): placarAtual = 0; pending, novoRecorde, volta and pointer cleared; placarMaximo kept.
- Entering FIM discards pending. placarAtual is frozen until the next round start.
- Assertion of reset at any time returns every output to its reset value asynchronously, including in the middle of a drain.

## Timing
- Kill latency: a flag falls before edge k → pending set at edge k → grant, increment and pontoPulso after edge k+1.
- Throughput: one point per cycle. A burst of M simultaneous kills drains in M consecutive cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- estado changes on the edge after the triggering input is sampled high.

## Structure
- Package placar_pkg holds:
  - estado_t enum: OCIOSO = 0, JOGANDO = 1, FIM = 2
  - SCORE_W = 10
  - SCORE_MAX_DEF = 999
- Sub-module arbitro_rr (parameter N):
  - inputs: req[N-1:0], ptr
  - outputs: grant one-hot, grant_idx, valid
  - purely combinational; the pointer register lives in controle_placar.

## Test plan
- Reset release, then iniciarJogo; clear vida[3], vida[7], vida[20] in one cycle → estado = 1; three pontoPulso in consecutive cycles, first 2 cycles after the fall, grant order 3, 7, 20; placarAtual = 3; placarMaximo = 3; novoRecorde = 1.
- With pointer = 8, kill bits 2 and 9 together → grant order 9 then 2.
- Kills while in OCIOSO or FIM, then iniciarJogo with flags already 0 → no points counted.
- Preload the score to 998 via kills with SCORE_MAX = 999, then two more kills → placarAtual 999 then 0; volta = 1; placarMaximo stays 999.
- perdeuJogo while 5 kills are pending → estado = 2 the next cycle; placarAtual frozen; pending dropped. reiniciarJogo → estado = 1, placarAtual = 0, placarMaximo unchanged, novoRecorde = 0.
- Assert reset in the middle of a drain, then release → all outputs 0 asynchronously; no stale pontoPulso after release.
